// File: rtl/fp_pool_arbiter.sv
// Grants the shared floating-point operator pool to the FIR filter or FFT engine and
// steers results back to the issuer via an op_sel delay line matched to pool latency.
module fp_pool_arbiter #(
  parameter int LAT   = 8,
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_filt,
  input  logic       rel_filt,
  input  logic       req_fft,
  input  logic       rel_fft,
  output logic       gnt_filt,
  output logic       gnt_fft,
  output logic [1:0] op_sel,
  output logic [1:0] res_sel,
  output logic       busy,
  output logic [7:0] handovers,
  output logic [1:0] dbg_state
);

  // Handshake: req_x is a level held while x wants the pool; gnt_x is registered and
  // stays high until the owner pulses rel_x for one cycle. rel from a non-owner is ignored,
  // and rel wins over a concurrent req from the owner.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_FILT = 2'd1,
    OWN_FFT  = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_cnt;
  logic [4:0] w_cnt_nxt;
  logic       r_last_fft;
  logic       w_last_fft_nxt;
  logic [7:0] r_handovers;
  logic       w_release;
  logic       w_filt_wins;
  logic [1:0] r_res_pipe [LAT];

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_last_fft_nxt = r_last_fft;
    w_release      = 1'b0;
    // Filter wins a tie under fixed priority, or under round-robin when FFT owned last.
    w_filt_wins    = req_filt && (!req_fft || (RR_EN == 0) || r_last_fft);
    case (r_state)
      IDLE: begin
        if (w_filt_wins) begin
          w_state_nxt    = OWN_FILT;
          w_last_fft_nxt = 1'b0;
        end else if (req_fft) begin
          w_state_nxt    = OWN_FFT;
          w_last_fft_nxt = 1'b1;
        end
      end
      OWN_FILT: begin
        if (rel_filt) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = 5'(LAT - 1);
          w_release   = 1'b1;
        end
      end
      OWN_FFT: begin
        if (rel_fft) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = 5'(LAT - 1);
          w_release   = 1'b1;
        end
      end
      DRAIN: begin
        if (r_cnt == 5'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 5'd0;
      r_last_fft  <= 1'b1;
      r_handovers <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last_fft <= w_last_fft_nxt;
      if (w_release) begin
        r_handovers <= r_handovers + 8'd1;
      end
    end
  end

  // Result steering: a pure LAT-deep copy of op_sel, no bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_res_pipe[i] <= 2'b00;
      end
    end else begin
      r_res_pipe[0] <= op_sel;
      for (int i = 1; i < LAT; i++) begin
        r_res_pipe[i] <= r_res_pipe[i-1];
      end
    end
  end

  assign gnt_filt  = (r_state == OWN_FILT);
  assign gnt_fft   = (r_state == OWN_FFT);
  assign op_sel    = {gnt_fft, gnt_filt};
  assign res_sel   = r_res_pipe[LAT-1];
  assign busy      = (r_state != IDLE);
  assign handovers = r_handovers;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_pool_arbiter.sv
// Bench for fp_pool_arbiter: two instances (LAT 8 round-robin, LAT 3 fixed priority) share
// stimulus and are checked every cycle against an event-time model of pool ownership.
module tb_fp_pool_arbiter;

  localparam int LAT0 = 8;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_filt = 1'b0;
  logic rel_filt = 1'b0;
  logic req_fft = 1'b0;
  logic rel_fft = 1'b0;

  logic [1:0]      gf;
  logic [1:0]      gt;
  logic [1:0][1:0] os;
  logic [1:0][1:0] rs;
  logic [1:0]      bz;
  logic [1:0][7:0] ho;
  logic [1:0][1:0] st;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  fp_pool_arbiter #(.LAT(LAT0), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .req_filt(req_filt), .rel_filt(rel_filt),
    .req_fft(req_fft), .rel_fft(rel_fft), .gnt_filt(gf[0]), .gnt_fft(gt[0]),
    .op_sel(os[0]), .res_sel(rs[0]), .busy(bz[0]), .handovers(ho[0]), .dbg_state(st[0])
  );

  fp_pool_arbiter #(.LAT(LAT1), .RR_EN(0)) u_fix (
    .clk(clk), .rst(rst), .req_filt(req_filt), .rel_filt(rel_filt),
    .req_fft(req_fft), .rel_fft(rel_fft), .gnt_filt(gf[1]), .gnt_fft(gt[1]),
    .op_sel(os[1]), .res_sel(rs[1]), .busy(bz[1]), .handovers(ho[1]), .dbg_state(st[1])
  );

  // Reference model: owner (0 none, 1 filt, 2 fft), edge index k, and the edge at which
  // the pool may be arbitrated again after a release; res_sel read from an op_sel history.
  int         m_owner [2];
  int         m_last  [2];
  int         m_free  [2];
  int         m_k     [2];
  logic [7:0] m_hand  [2];
  logic [1:0] m_hist  [2][64];

  function automatic int lat_of(int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int rr_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0;
      m_last[i]  = 2;
      m_free[i]  = 0;
      m_k[i]     = 0;
      m_hand[i]  = 8'd0;
      for (int j = 0; j < 64; j++) m_hist[i][j] = 2'b00;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int k;
      int win;
      m_k[i] = m_k[i] + 1;
      k = m_k[i];
      if (m_owner[i] == 1 && rel_filt) begin
        m_owner[i] = 0;
        m_free[i]  = k + lat_of(i) + 1;
        m_hand[i]  = m_hand[i] + 8'd1;
      end else if (m_owner[i] == 2 && rel_fft) begin
        m_owner[i] = 0;
        m_free[i]  = k + lat_of(i) + 1;
        m_hand[i]  = m_hand[i] + 8'd1;
      end else if (m_owner[i] == 0 && k >= m_free[i]) begin
        win = 0;
        if (req_filt && req_fft) win = (rr_of(i) != 0 && m_last[i] == 1) ? 2 : 1;
        else if (req_filt) win = 1;
        else if (req_fft) win = 2;
        if (win != 0) begin
          m_owner[i] = win;
          m_last[i]  = win;
        end
      end
      m_hist[i][k % 64] = 2'(m_owner[i]);
    end
  endtask

  function automatic int exp_busy(int i);
    return (m_owner[i] != 0 || m_k[i] < m_free[i] - 1) ? 1 : 0;
  endfunction

  function automatic int exp_res(int i);
    return (m_k[i] >= lat_of(i)) ? int'(m_hist[i][(m_k[i] - lat_of(i)) % 64]) : 0;
  endfunction

  function automatic int exp_state(int i);
    if (m_owner[i] != 0) return m_owner[i];
    return (exp_busy(i) != 0) ? 3 : 0;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // scoreboard
  task automatic check(string name, int inst, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s inst%0d t=%0t actual=%0d expected=%0d", name, inst, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          check("onehot_gnt", i, int'(gf[i] && gt[i]), 0);
          check("gnt_filt", i, int'(gf[i]), int'(m_owner[i] == 1));
          check("gnt_fft", i, int'(gt[i]), int'(m_owner[i] == 2));
          check("op_sel", i, int'(os[i]), m_owner[i]);
          check("res_sel", i, int'(rs[i]), exp_res(i));
          check("busy", i, int'(bz[i]), exp_busy(i));
          check("handovers", i, int'(ho[i]), int'(m_hand[i]));
          check("dbg_state", i, int'(st[i]), exp_state(i));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_filt = 1'b0; rel_filt = 1'b0; req_fft = 1'b0; rel_fft = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 2; i++) begin
      check("rst_gnt", i, int'(gf[i] | gt[i]), 0);
      check("rst_op_sel", i, int'(os[i]), 0);
      check("rst_res_sel", i, int'(rs[i]), 0);
      check("rst_busy", i, int'(bz[i]), 0);
      check("rst_handovers", i, int'(ho[i]), 0);
    end

    // Simultaneous first request: filter wins in both modes.
    req_filt = 1'b1; req_fft = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      check("tie_gnt_filt", i, int'(gf[i]), 1);
      check("tie_gnt_fft", i, int'(gt[i]), 0);
      check("tie_op_sel", i, int'(os[i]), 1);
      check("tie_busy", i, int'(bz[i]), 1);
    end
    repeat (LAT0 - 1) tick();
    check("res_before_lat", 0, int'(rs[0]), 0);
    tick();
    check("res_at_lat", 0, int'(rs[0]), 1);

    // Non-owner release and owner dropping req do not end ownership.
    rel_fft = 1'b1; req_filt = 1'b0;
    tick();
    rel_fft = 1'b0;
    tick();
    check("inv_gnt_filt", 0, int'(gf[0]), 1);
    check("inv_handovers", 0, int'(ho[0]), 0);

    // Handover filter -> FFT with drain.
    rel_filt = 1'b1;
    tick();
    rel_filt = 1'b0;
    check("rel_op_sel", 0, int'(os[0]), 0);
    check("rel_busy", 0, int'(bz[0]), 1);
    check("rel_handovers", 0, int'(ho[0]), 1);
    check("rel_res_sel", 0, int'(rs[0]), 1);
    repeat (LAT0 - 1) tick();
    check("drain_res_sel", 0, int'(rs[0]), 1);
    check("drain_gnt_fft", 0, int'(gt[0]), 0);
    tick();
    check("drain_end_res", 0, int'(rs[0]), 0);
    check("drain_end_gnt", 0, int'(gt[0]), 0);
    tick();
    check("handover_gnt_fft", 0, int'(gt[0]), 1);
    check("handover_op_sel", 0, int'(os[0]), 2);

    // Both requesting at every release: round-robin alternates, fixed keeps filter.
    req_filt = 1'b1; rel_fft = 1'b1;
    tick();
    rel_fft = 1'b0;
    repeat (LAT0 + 1) tick();
    check("rr_gnt_filt", 0, int'(gf[0]), 1);
    check("fix_gnt_filt", 1, int'(gf[1]), 1);
    rel_filt = 1'b1;
    tick();
    rel_filt = 1'b0;
    repeat (LAT0 + 1) tick();
    check("rr_alt_gnt_fft", 0, int'(gt[0]), 1);
    check("fix_again_filt", 1, int'(gf[1]), 1);
    check("rr_handovers", 0, int'(ho[0]), 3);
    check("fix_handovers", 1, int'(ho[1]), 3);

    // Asynchronous reset between clock edges while the FFT owns the pool.
    tick();
    #4;
    rst = 1'b1;
    #1;
    check("arst_gnt_fft", 0, int'(gt[0]), 0);
    check("arst_op_sel", 0, int'(os[0]), 0);
    check("arst_res_sel", 0, int'(rs[0]), 0);
    check("arst_busy", 0, int'(bz[0]), 0);
    check("arst_handovers", 0, int'(ho[0]), 0);
    tick();
    rst = 1'b0;

    // Random traffic, with one reset mid-run.
    req_filt = 1'b0; req_fft = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) req_filt = ~req_filt;
      if ($urandom_range(0, 7) == 0) req_fft = ~req_fft;
      rel_filt = ($urandom_range(0, 5) == 0);
      rel_fft  = ($urandom_range(0, 5) == 0);
      if (n == 1000) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    // Handover counter wrap after 256 grants.
    do_reset();
    req_filt = 1'b1;
    for (int n = 0; n < 256; n++) begin
      for (int t = 0; t < 40 && !gf[0]; t++) tick();
      check("wrap_grant", 0, int'(gf[0]), 1);
      if (n == 255) check("wrap_255", 0, int'(ho[0]), 255);
      rel_filt = 1'b1;
      tick();
      rel_filt = 1'b0;
    end
    check("wrap_zero", 0, int'(ho[0]), 0);
    check("wrap_zero", 1, int'(ho[1]), 0);
    req_filt = 1'b0;
    repeat (LAT0 + 3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_pool_arbiter.md
Name: fp_pool_arbiter

Overview:
- Arbitrates the shared floating-point operator pool (adder1, adder2/total, mult, mult2) between two requesters: the FIR filter engine and the FFT engine.
- Produces the issue-side mux select that steers operands into the pool.
- Produces a result-side select, delayed by the operator pipeline latency, so in-flight results return to the requester that issued them.
- Replaces the hand-sequenced mux register in the top-level controller.
- Sits between the top-level sequencer and the operator mux.

Parameters:
- LAT, 8: operator pipeline depth in cycles, taken as the maximum over the adder and multiplier cores. Legal range 1..31.
- RR_EN, 1: 1 = round-robin between requesters; 0 = fixed priority, filter highest.

Ports:
- clk, in, 1: system clock; all state updates on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req_filt, in, 1: filter requests the pool (level).
- rel_filt, in, 1: filter releases the pool (single-cycle pulse).
- req_fft, in, 1: FFT requests the pool (level).
- rel_fft, in, 1: FFT releases the pool (single-cycle pulse).
- gnt_filt, out, 1: filter owns the pool.
- gnt_fft, out, 1: FFT owns the pool.
- op_sel, out, 2: issue-side mux select. 00 = none, 01 = filter, 10 = FFT. 11 is never driven.
- res_sel, out, 2: result-side select; op_sel delayed by exactly LAT cycles.
- busy, out, 1: high in any state other than IDLE.
- handovers, out, 8: count of completed grants; wraps 255 -> 0.

Behaviour:
- Reset (async, immediate): state = IDLE; gnt_* = 0; op_sel = 00; every res_sel delay stage = 00; drain counter = 0; handovers = 0; last-owner pointer = FFT, so the filter wins the first contention.
- States:
  - IDLE
  - OWN_FILT
  - OWN_FFT
  - DRAIN
- IDLE:
  - Sampled requests decide the next state; the grant is registered.
  - If only one request is high, that requester wins.
  - If both are high and RR_EN = 1, the requester that is not the last owner wins.
  - If both are high and RR_EN = 0, the filter wins.
  - On the edge where the winner is chosen: gnt_x = 1, op_sel = its code, last-owner pointer updated.
  - Grant latency: request high at edge N gives grant high after edge N. Worst case from IDLE is 1 cycle.
  - No request: stay in IDLE with op_sel = 00.
- OWN_x:
  - Grant is held until rel_x is sampled high; deassertion of req_x alone does not end ownership.
  - On rel_x: gnt_x = 0, op_sel = 00, drain counter loaded with LAT-1, go to DRAIN, handovers += 1.
  - A rel from the non-owner is ignored.
  - req_x and rel_x high together from the owner: release wins.
- DRAIN:
  - No grants are issued.
  - The counter decrements each cycle; when it reads 0, go to IDLE.
  - A requester waiting at release therefore sees a grant LAT+1 cycles after the edge that sampled rel.
  - During DRAIN, res_sel still carries the previous owner's code until its last issued operation has emerged.
- res_sel: LAT-stage shift register of op_sel, with no bypass. res_sel(t) = op_sel(t-LAT).
- Invariants:
  - gnt_filt and gnt_fft are never both high.
  - op_sel = 01 iff gnt_filt; op_sel = 10 iff gnt_fft.
- Reset mid-operation: all outputs drop on the reset edge without waiting for the clock. In-flight pool results are discarded, because res_sel is forced to 00.
- A request arriving in the same cycle as DRAIN's final count is arbitrated on the following IDLE edge. No request is lost, because requests are levels.

Test Plan:
- Single filter request: assert rst, release it, then raise req_filt at cycle 2 -> gnt_filt = 1 and op_sel = 01 from cycle 3; res_sel = 01 from cycle 3+LAT (11 with LAT = 8); busy = 1.
- Handover: filter owns, req_fft held high, rel_filt pulsed at cycle 20 -> op_sel = 00 at 21; gnt_fft = 1 and op_sel = 10 at 29 (LAT = 8); res_sel = 01 through cycle 28 and 00 at 29; handovers = 1.
- Simultaneous request: both requests rise in the same cycle after reset -> filter granted; after its release and drain, FFT granted. Repeat with RR_EN = 1 -> next tie goes to filter again (alternation). With RR_EN = 0 -> filter always wins.
- Invalid release: while the filter owns, pulse rel_fft, and drop req_filt without rel_filt -> no state change, gnt_filt stays 1, handovers unchanged.
- Async reset during OWN_FFT at a non-clock-aligned time -> gnt_fft, op_sel, res_sel and busy read 0 before the next edge; handovers = 0.
- Counter wrap: 256 alternating grant/release cycles -> handovers reads 0. The one-hot grant invariant is checked by assertion every cycle.
